change_hopper_ctrl: RTL and testbench
=====================================

# change_hopper_ctrl

Change-return coin hopper controller on the dispensing side of the soda machine. It receives the one-cycle 100-yen change count the vending controller emits and queues it. It then pays out coins one at a time by running the hopper motor and counting coin-sensor pulses, while tracking hopper inventory and detecting jams and the empty condition.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1000: maximum motor-on cycles per coin before a jam is declared (≥2).
- GAP_CYCLES, 4: motor-off settle cycles after each coin (≥1).
- INVENTORY_INIT, 100: coin count loaded at reset (0..255).

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- change_request  in  4  coins to pay out; nonzero value is a one-cycle request, 0 means none.
- coin_sensor  in  1  hopper exit sensor, synchronous level, high while a coin passes.
- refill  in  1  one-cycle pulse: add refill_count to inventory.
- refill_count  in  8  coins added on refill.
- clear_fault  in  1  one-cycle pulse: leave FAULT.
- hopper_motor  out  1  motor drive; high only in MOTOR.
- coin_out  out  1  one-cycle pulse per counted coin.
- busy  out  1  high whenever pending ≠ 0 or state ≠ IDLE.
- pending  out  6  coins still owed.
- inventory  out  8  coins believed in hopper.
- hopper_empty  out  1  high while pending ≠ 0 and inventory = 0.
- jam_error  out  1  high while in FAULT.
- overflow  out  1  one-cycle pulse when a request saturates pending.

## Operation
- States: IDLE, MOTOR, GAP, FAULT. All outputs are registered.
- Reset values: state IDLE, pending 0, inventory INVENTORY_INIT, timer 0, and every 1-bit output 0.
- Sensor edge: the block registers coin_sensor as sensor_d. edge = coin_sensor & ~sensor_d. sensor_d resets to 0.
- Pending update each cycle: next = pending + change_request − (counted edge ? 1 : 0), saturating at 63. If saturation clips the sum, overflow pulses the next cycle.
- IDLE → MOTOR when pending ≠ 0 and inventory ≠ 0. The timer clears to 0 on entry.
- MOTOR:
  - On an edge: pending −1, inventory −1 (the only counted edge), coin_out pulses, go to GAP.
  - With no edge and timer = TIMEOUT_CYCLES−1: go to FAULT. Otherwise timer +1.
- GAP:
  - Lasts exactly GAP_CYCLES cycles; edges here are ignored.
  - Then go to MOTOR if pending ≠ 0 and inventory ≠ 0, else IDLE.
- FAULT:
  - Motor off; requests still accumulate into pending.
  - clear_fault → IDLE. clear_fault in any other state has no effect.
- Inventory:
  - Refill adds refill_count, saturating at 255, and is accepted in every state.
  - If a counted coin and a refill land in the same cycle: inventory + refill_count − 1, saturating.
  - If inventory reaches 0 while pending ≠ 0, the block goes to IDLE after GAP and holds hopper_empty. A later refill restarts payout automatically.
- Edges in IDLE, GAP or FAULT never change pending or inventory.
- A reset mid-payout abandons pending coins. The motor drops asynchronously with reset.

## Timing
- A request sampled at the clock edge ending cycle N gives updated pending in cycle N+1. From IDLE, hopper_motor goes high in cycle N+2.
- A sensor rising level sampled at the edge ending cycle M gives, in cycle M+1: hopper_motor low, coin_out high, pending and inventory decremented.
- Motor-on duration per coin is at most TIMEOUT_CYCLES cycles. jam_error rises in the cycle after the last motor-on cycle.
- An edge in the final timeout cycle counts as a coin; there is no fault.
- After GAP, hopper_motor is low for exactly GAP_CYCLES cycles before the next coin.
- busy falls in the cycle after GAP ends with pending = 0.
- hopper_empty and busy are registered from next-state values, so they are valid in the same cycle as pending.

## Test plan
- Reset, then change_request=3 for one cycle, with the sensor pulsed 5 cycles into each motor phase → three coin_out pulses, 4-cycle motor-off gaps, pending 3→0, inventory 100→97, busy low afterwards.
- change_request=2 with no sensor activity (TIMEOUT_CYCLES=8) → motor high for exactly 8 cycles, then jam_error=1 and pending=2. Then clear_fault → motor restarts, and two sensor pulses bring pending to 0.
- INVENTORY_INIT=1, change_request=4 → one coin paid, then inventory=0, pending=3, hopper_empty=1, motor idle. Then refill with refill_count=10 → payout resumes, ending with inventory=7.
- Five consecutive change_request=15 cycles with the sensor never pulsing → pending saturates at 63 and overflow pulses once, on the cycle after the fifth request.
- change_request=1 in the same cycle a counted edge is sampled while pending=2 → pending stays 2 and coin_out pulses.
- reset asserted mid-MOTOR with pending=5 → motor low immediately, pending=0, inventory=100, state IDLE.

Source files
------------

// File: rtl/change_hopper_ctrl.sv
// change_hopper_ctrl
// Change-return coin hopper controller. It accumulates 100-yen change requests
// into a pending count and pays coins out one at a time. For each coin it runs
// the hopper motor until the exit sensor shows a rising edge, then lets the
// mechanism settle before the next coin. It also tracks hopper inventory and
// reports jams (no coin within TIMEOUT_CYCLES) and the empty condition.
//
// Ports
//   clock          system clock, rising edge
//   reset          asynchronous active-high reset, clears all state
//   change_request coins to pay out (nonzero = one-cycle request)
//   coin_sensor    hopper exit sensor level (synchronous)
//   refill         one-cycle pulse: add refill_count to inventory
//   refill_count   coins added on refill
//   clear_fault    one-cycle pulse: leave FAULT
//   hopper_motor   motor drive, high only while paying a coin
//   coin_out       one-cycle pulse per counted coin
//   busy           pending != 0 or controller not idle
//   pending        coins still owed
//   inventory      coins believed to be in the hopper
//   hopper_empty   coins owed but inventory exhausted
//   jam_error      high while in FAULT
//   overflow       one-cycle pulse when a request saturates pending
module change_hopper_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int GAP_CYCLES     = 4,
    parameter int INVENTORY_INIT = 100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] change_request,
    input  logic       coin_sensor,
    input  logic       refill,
    input  logic [7:0] refill_count,
    input  logic       clear_fault,
    output logic       hopper_motor,
    output logic       coin_out,
    output logic       busy,
    output logic [5:0] pending,
    output logic [7:0] inventory,
    output logic       hopper_empty,
    output logic       jam_error,
    output logic       overflow
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
    localparam logic [7:0]    INV_RESET  = 8'(INVENTORY_INIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOTOR = 2'd1,
        GAP   = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [GW-1:0] gap_cnt, gap_cnt_n;
    logic          sensor_d;
    logic          sensor_edge;
    logic          counted;
    logic [5:0]    pending_n;
    logic [7:0]    inventory_n;
    logic          overflow_n;

    // Pending update, saturating at 63. Bit 6 of the result flags a clipped sum.
    // A decrement only happens in MOTOR, which is never entered with pending = 0.
    function automatic logic [6:0] sat_pending(input logic [5:0] cur,
                                               input logic [3:0] req,
                                               input logic       dec);
        logic [6:0] sum;
        sum = {1'b0, cur} + {3'b000, req} - {6'd0, dec};
        if (sum > 7'd63)
            return {1'b1, 6'd63};
        return {1'b0, sum[5:0]};
    endfunction

    // Inventory update with optional refill and coin, saturating at 255.
    // A coin is only counted in MOTOR, which requires inventory != 0.
    function automatic logic [7:0] sat_inventory(input logic [7:0] cur,
                                                 input logic       add,
                                                 input logic [7:0] amount,
                                                 input logic       dec);
        logic [8:0] sum;
        sum = {1'b0, cur} + (add ? {1'b0, amount} : 9'd0) - {8'd0, dec};
        if (sum > 9'd255)
            return 8'd255;
        return sum[7:0];
    endfunction

    assign sensor_edge = coin_sensor & ~sensor_d;

    // Next-state, counters and the pending/inventory arithmetic
    always_comb begin
        state_n   = state;
        timer_n   = timer;
        gap_cnt_n = gap_cnt;
        counted   = 1'b0;

        case (state)
            IDLE: begin
                if (pending != 6'd0 && inventory != 8'd0) begin
                    state_n = MOTOR;
                    timer_n = '0;
                end
            end
            MOTOR: begin
                // An edge in the last timeout cycle still wins over the jam.
                if (sensor_edge) begin
                    counted   = 1'b1;
                    state_n   = GAP;
                    gap_cnt_n = '0;
                end else if (timer == TIMER_LAST) begin
                    state_n = FAULT;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    if (pending != 6'd0 && inventory != 8'd0) begin
                        state_n = MOTOR;
                        timer_n = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    gap_cnt_n = gap_cnt + 1'b1;
                end
            end
            FAULT: begin
                if (clear_fault)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        {overflow_n, pending_n} = sat_pending(pending, change_request, counted);
        inventory_n = sat_inventory(inventory, refill, refill_count, counted);
    end

    // State and registered outputs; status flags come from next-state values
    // so they line up with the pending count they describe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= '0;
            gap_cnt      <= '0;
            sensor_d     <= 1'b0;
            pending      <= 6'd0;
            inventory    <= INV_RESET;
            hopper_motor <= 1'b0;
            coin_out     <= 1'b0;
            busy         <= 1'b0;
            hopper_empty <= 1'b0;
            jam_error    <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            state        <= state_n;
            timer        <= timer_n;
            gap_cnt      <= gap_cnt_n;
            sensor_d     <= coin_sensor;
            pending      <= pending_n;
            inventory    <= inventory_n;
            hopper_motor <= (state_n == MOTOR);
            coin_out     <= counted;
            busy         <= (pending_n != 6'd0) || (state_n != IDLE);
            hopper_empty <= (pending_n != 6'd0) && (inventory_n == 8'd0);
            jam_error    <= (state_n == FAULT);
            overflow     <= overflow_n;
        end
    end

endmodule

// File: tb/tb_change_hopper_ctrl.sv
// tb_change_hopper_ctrl
// Self-checking bench for change_hopper_ctrl. Two instances share stimulus:
// dut_a starts with 100 coins, dut_b with 1 coin; both use an 8-cycle timeout
// and a 4-cycle gap. Expected pending/inventory after each coin are queued when
// the sensor is driven and compared when coin_out appears.
module tb_change_hopper_ctrl;

    localparam int GAP = 4;

    logic       clock          = 1'b0;
    logic       reset          = 1'b1;
    logic [3:0] change_request = 4'd0;
    logic       coin_sensor    = 1'b0;
    logic       refill         = 1'b0;
    logic [7:0] refill_count   = 8'd0;
    logic       clear_fault    = 1'b0;
    logic       sel            = 1'b0;

    logic       a_motor, a_coin, a_busy, a_empty, a_jam, a_ovf;
    logic [5:0] a_pend;
    logic [7:0] a_inv;
    logic       b_motor, b_coin, b_busy, b_empty, b_jam, b_ovf;
    logic [5:0] b_pend;
    logic [7:0] b_inv;

    logic       o_motor, o_coin_out, o_busy, o_empty, o_jam, o_ovf;
    logic [5:0] o_pending;
    logic [7:0] o_inventory;

    typedef struct {
        int pend;
        int inv;
    } coin_exp_t;

    coin_exp_t exp_q[$];
    coin_exp_t mon_e;
    int n_checks   = 0;
    int n_pass     = 0;
    int coins_seen = 0;
    int exp_pending;
    int exp_inv;

    change_hopper_ctrl #(
        .TIMEOUT_CYCLES(8), .GAP_CYCLES(GAP), .INVENTORY_INIT(100)
    ) dut_a (
        .clock(clock), .reset(reset), .change_request(change_request),
        .coin_sensor(coin_sensor), .refill(refill), .refill_count(refill_count),
        .clear_fault(clear_fault), .hopper_motor(a_motor), .coin_out(a_coin),
        .busy(a_busy), .pending(a_pend), .inventory(a_inv),
        .hopper_empty(a_empty), .jam_error(a_jam), .overflow(a_ovf)
    );

    change_hopper_ctrl #(
        .TIMEOUT_CYCLES(8), .GAP_CYCLES(GAP), .INVENTORY_INIT(1)
    ) dut_b (
        .clock(clock), .reset(reset), .change_request(change_request),
        .coin_sensor(coin_sensor), .refill(refill), .refill_count(refill_count),
        .clear_fault(clear_fault), .hopper_motor(b_motor), .coin_out(b_coin),
        .busy(b_busy), .pending(b_pend), .inventory(b_inv),
        .hopper_empty(b_empty), .jam_error(b_jam), .overflow(b_ovf)
    );

    always_comb begin
        o_motor     = sel ? b_motor : a_motor;
        o_coin_out  = sel ? b_coin  : a_coin;
        o_busy      = sel ? b_busy  : a_busy;
        o_empty     = sel ? b_empty : a_empty;
        o_jam       = sel ? b_jam   : a_jam;
        o_ovf       = sel ? b_ovf   : a_ovf;
        o_pending   = sel ? b_pend  : a_pend;
        o_inventory = sel ? b_inv   : a_inv;
    end

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    // Scoreboard consumer: each coin_out pops the expected counts.
    always @(negedge clock) begin
        if (o_coin_out) begin
            coins_seen++;
            if (exp_q.size() == 0) begin
                check("coin_unexpected", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("coin_pending", int'(o_pending), mon_e.pend);
                check("coin_inventory", int'(o_inventory), mon_e.inv);
            end
        end
    end

    task automatic do_reset(input logic which);
        check("sb_drained", exp_q.size(), 0);
        exp_q.delete();
        change_request = 4'd0;
        coin_sensor    = 1'b0;
        refill         = 1'b0;
        refill_count   = 8'd0;
        clear_fault    = 1'b0;
        sel            = which;
        reset          = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Waits for the motor, drives one sensor pulse after 'delay' motor cycles,
    // optionally with a simultaneous request, and measures the following gap.
    task automatic run_coin(input string tag, input int delay, input bit more,
                            input logic [3:0] extra);
        int n;
        coin_exp_t e;
        n = 0;
        while (!o_motor && n < 40) begin
            step();
            n++;
        end
        check({tag, "_motor_on"}, int'(o_motor), 1);
        repeat (delay) step();
        check({tag, "_motor_still_on"}, int'(o_motor), 1);
        exp_pending = exp_pending + int'(extra) - 1;
        exp_inv     = exp_inv - 1;
        e.pend = exp_pending;
        e.inv  = exp_inv;
        exp_q.push_back(e);
        coin_sensor    = 1'b1;
        change_request = extra;
        step();
        change_request = 4'd0;
        check({tag, "_motor_off"}, int'(o_motor), 0);
        check({tag, "_coin_pulse"}, int'(o_coin_out), 1);
        n = 1;
        step();
        coin_sensor = 1'b0;
        check({tag, "_coin_single"}, int'(o_coin_out), 0);
        if (more) begin
            while (!o_motor && n < 20) begin
                n++;
                step();
            end
            check({tag, "_gap_cycles"}, n, GAP);
        end
    endtask

    initial begin
        int base;
        int on;
        int n;

        // Reset values and a three-coin payout
        do_reset(1'b0);
        check("rst_pending", int'(o_pending), 0);
        check("rst_inventory", int'(o_inventory), 100);
        check("rst_motor", int'(o_motor), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_jam", int'(o_jam), 0);
        check("rst_empty", int'(o_empty), 0);
        check("rst_overflow", int'(o_ovf), 0);
        check("rst_coin", int'(o_coin_out), 0);
        change_request = 4'd3;
        step();
        change_request = 4'd0;
        check("t1_pending_n1", int'(o_pending), 3);
        check("t1_busy_n1", int'(o_busy), 1);
        check("t1_motor_n1", int'(o_motor), 0);
        step();
        check("t1_motor_n2", int'(o_motor), 1);
        exp_pending = 3;
        exp_inv     = 100;
        base        = coins_seen;
        run_coin("t1c1", 5, 1'b1, 4'd0);
        run_coin("t1c2", 5, 1'b1, 4'd0);
        run_coin("t1c3", 5, 1'b0, 4'd0);
        step();
        step();
        check("t1_busy_last_gap", int'(o_busy), 1);
        step();
        check("t1_busy_fall", int'(o_busy), 0);
        check("t1_pending_end", int'(o_pending), 0);
        check("t1_inventory_end", int'(o_inventory), 97);
        check("t1_coins", coins_seen - base, 3);

        // Jam timeout, requests and edges during FAULT, clear, boundary coin
        do_reset(1'b0);
        change_request = 4'd2;
        step();
        change_request = 4'd0;
        n = 0;
        while (!o_motor && n < 10) begin
            step();
            n++;
        end
        on = 0;
        while (o_motor && on < 40) begin
            on++;
            step();
        end
        check("t2_motor_cycles", on, 8);
        check("t2_jam", int'(o_jam), 1);
        check("t2_pending_fault", int'(o_pending), 2);
        check("t2_busy_fault", int'(o_busy), 1);
        change_request = 4'd1;
        step();
        change_request = 4'd0;
        check("t2_fault_accumulate", int'(o_pending), 3);
        coin_sensor = 1'b1;
        step();
        coin_sensor = 1'b0;
        check("t2_fault_edge_pending", int'(o_pending), 3);
        check("t2_fault_edge_inventory", int'(o_inventory), 100);
        check("t2_fault_edge_coin", int'(o_coin_out), 0);
        check("t2_jam_hold", int'(o_jam), 1);
        clear_fault = 1'b1;
        step();
        clear_fault = 1'b0;
        check("t2_jam_clear", int'(o_jam), 0);
        exp_pending = 3;
        exp_inv     = 100;
        run_coin("t2c1", 2, 1'b1, 4'd0);
        run_coin("t2c2", 2, 1'b1, 4'd0);
        run_coin("t2c3", 7, 1'b0, 4'd0);
        check("t2_last_cycle_no_jam", int'(o_jam), 0);
        check("t2_pending_end", int'(o_pending), 0);
        check("t2_inventory_end", int'(o_inventory), 97);

        // Empty hopper, then refill restarts payout (1-coin instance)
        do_reset(1'b1);
        check("t3_rst_inventory", int'(o_inventory), 1);
        change_request = 4'd4;
        step();
        change_request = 4'd0;
        exp_pending = 4;
        exp_inv     = 1;
        run_coin("t3c1", 3, 1'b0, 4'd0);
        repeat (5) step();
        check("t3_motor_idle", int'(o_motor), 0);
        check("t3_empty", int'(o_empty), 1);
        check("t3_pending", int'(o_pending), 3);
        check("t3_inventory_zero", int'(o_inventory), 0);
        check("t3_busy", int'(o_busy), 1);
        refill_count = 8'd10;
        refill       = 1'b1;
        step();
        refill = 1'b0;
        exp_inv = exp_inv + 10;
        check("t3_refill_inventory", int'(o_inventory), 10);
        check("t3_empty_clear", int'(o_empty), 0);
        run_coin("t3c2", 1, 1'b1, 4'd0);
        run_coin("t3c3", 1, 1'b1, 4'd0);
        run_coin("t3c4", 1, 1'b0, 4'd0);
        repeat (3) step();
        check("t3_inventory_end", int'(o_inventory), 7);
        check("t3_pending_end", int'(o_pending), 0);
        check("t3_busy_end", int'(o_busy), 0);

        // Pending saturation and a single overflow pulse
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) begin
            change_request = 4'd15;
            step();
            check($sformatf("t4_overflow_%0d", i), int'(o_ovf), (i == 4) ? 1 : 0);
            check($sformatf("t4_pending_%0d", i), int'(o_pending),
                  (15 * (i + 1) > 63) ? 63 : 15 * (i + 1));
        end
        change_request = 4'd0;
        step();
        check("t4_overflow_once", int'(o_ovf), 0);
        check("t4_pending_hold", int'(o_pending), 63);

        // Request coincident with a counted edge
        do_reset(1'b0);
        change_request = 4'd2;
        step();
        change_request = 4'd0;
        exp_pending = 2;
        exp_inv     = 100;
        run_coin("t5c1", 3, 1'b0, 4'd1);
        check("t5_pending_hold", int'(o_pending), 2);
        check("t5_inventory", int'(o_inventory), 99);

        // Asynchronous reset in the middle of a motor phase
        do_reset(1'b0);
        change_request = 4'd5;
        step();
        change_request = 4'd0;
        step();
        step();
        check("t6_motor_before", int'(o_motor), 1);
        check("t6_pending_before", int'(o_pending), 5);
        #2;
        reset = 1'b1;
        #1;
        check("t6_motor_async", int'(o_motor), 0);
        check("t6_pending_async", int'(o_pending), 0);
        check("t6_inventory_async", int'(o_inventory), 100);
        check("t6_busy_async", int'(o_busy), 0);
        step();
        reset = 1'b0;
        step();
        step();
        check("t6_motor_idle", int'(o_motor), 0);
        check("t6_busy_idle", int'(o_busy), 0);
        check("t6_pending_idle", int'(o_pending), 0);

        check("sb_drained_end", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
